// File: rtl/game_pkg.sv
// Shared definitions for the traffic scheduler: FSM state encoding, level width
// and the level-to-period table.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_PAUSE    = 3'd2,
        ST_LEVEL_UP = 3'd3,
        ST_OVER     = 3'd4
    } game_state_e;

    localparam int LEVEL_W       = 4;
    localparam int PERIOD_W      = 11;
    localparam int MAX_LEVEL_DEF = 9;

    // Base-tick period of lane 0 at a given level: 1100 - 100*L.
    function automatic logic [PERIOD_W-1:0] level_period(input logic [LEVEL_W-1:0] level);
        logic [PERIOD_W-1:0] lvl_ext;
        lvl_ext = PERIOD_W'(level);
        return 11'd1100 - 11'd100 * lvl_ext;
    endfunction

endpackage

// File: rtl/lane_timer.sv
// One lane counter: counts base ticks up to its period and emits a registered
// one-cycle step on the terminal tick.
module lane_timer
    import game_pkg::*;
(
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                tick,
    input  logic                clear,
    input  logic                step_en,
    input  logic [PERIOD_W-1:0] period,
    output logic                step
);

    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] cnt;

    // step_en low means the scheduler is leaving RUN this cycle: the count
    // still wraps but the pulse is dropped.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt  <= '0;
            step <= 1'b0;
        end else begin
            step <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == period - CNT_ONE) begin
                    cnt  <= '0;
                    step <= step_en;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/traffic_sched.sv
// Central traffic scheduler: prescaler, game FSM, level register and hold
// counter, driving one lane_timer per car lane.
module traffic_sched
    import game_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int TICK_DIV   = 250,
    parameter int LANE_SKEW  = 32,
    parameter int MAX_LEVEL  = MAX_LEVEL_DEF,
    parameter int HOLD_TICKS = 5000
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_start,
    input  logic                 i_goal,
    input  logic                 i_hit,
    input  logic                 i_pause,
    output logic [NUM_LANES-1:0] o_lane_step,
    output logic [LEVEL_W-1:0]   o_level,
    output logic                 o_level_chg,
    output logic [2:0]           o_state,
    output logic                 o_running
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]   PRE_ONE   = PRE_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);

    game_state_e         state, state_nxt;
    logic [PRE_W-1:0]    presc;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [LEVEL_W-1:0]  level_nxt;
    logic                ticking, base_tick;
    logic                lane_tick, lane_clear, step_en;
    logic [PERIOD_W-1:0] base_period;

    assign ticking   = (state == ST_RUN) || (state == ST_LEVEL_UP);
    assign base_tick = ticking && (presc == PRE_LAST);

    // Priority in RUN: hit over goal over pause; start only matters in IDLE/OVER.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_OVER: if (i_start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (i_hit)        state_nxt = ST_OVER;
                else if (i_goal)  state_nxt = ST_LEVEL_UP;
                else if (i_pause) state_nxt = ST_PAUSE;
            end
            ST_PAUSE: if (!i_pause) state_nxt = ST_RUN;
            ST_LEVEL_UP: begin
                if (base_tick && (hold_cnt == HOLD_LAST))
                    state_nxt = i_pause ? ST_PAUSE : ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        level_nxt = o_level;
        if ((state == ST_RUN) && (state_nxt == ST_LEVEL_UP) && (o_level < LEVEL_MAX))
            level_nxt = o_level + LEVEL_ONE;
        else if (((state == ST_IDLE) || (state == ST_OVER)) && (state_nxt == ST_RUN))
            level_nxt = LEVEL_ONE;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= ST_IDLE;
            o_level     <= LEVEL_ONE;
            o_level_chg <= 1'b0;
            presc       <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            o_level     <= level_nxt;
            o_level_chg <= (level_nxt != o_level);

            // PAUSE neither advances nor clears the prescaler.
            if ((state == ST_IDLE) || (state == ST_OVER))
                presc <= '0;
            else if (ticking)
                presc <= base_tick ? '0 : presc + PRE_ONE;

            if (state != ST_LEVEL_UP)
                hold_cnt <= '0;
            else if (base_tick)
                hold_cnt <= hold_cnt + HOLD_ONE;
        end
    end

    assign o_state   = state;
    assign o_running = (state == ST_RUN);

    assign lane_tick   = base_tick && (state == ST_RUN);
    assign lane_clear  = (state == ST_IDLE) || (state == ST_OVER) || (state == ST_LEVEL_UP);
    assign step_en     = (state_nxt == ST_RUN);
    assign base_period = level_period(o_level);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam logic [PERIOD_W-1:0] SKEW_K = PERIOD_W'(k * LANE_SKEW);

        lane_timer u_lane_timer (
            .i_Clk   (i_Clk),
            .i_Rst_n (i_Rst_n),
            .tick    (lane_tick),
            .clear   (lane_clear),
            .step_en (step_en),
            .period  (base_period + SKEW_K),
            .step    (o_lane_step[k])
        );
    end

endmodule

// File: tb/tb_traffic_sched.sv
// Bench for traffic_sched: directed scenarios plus random game events, checked
// every cycle against a behavioural model of the scheduler rules.
`timescale 1ns/1ps
module tb_traffic_sched;
    import game_pkg::*;

    localparam int NL   = 2;
    localparam int TD   = 4;
    localparam int SKEW = 2;
    localparam int HOLD = 3;
    localparam int MAXL = 9;
    localparam int W    = 3 + 4 + 1 + 1 + NL;

    // ---------------- clock / reset ----------------
    logic i_Clk   = 1'b0;
    logic i_Rst_n = 1'b0;
    logic i_start = 1'b0;
    logic i_goal  = 1'b0;
    logic i_hit   = 1'b0;
    logic i_pause = 1'b0;

    logic [NL-1:0] o_lane_step;
    logic [3:0]    o_level;
    logic          o_level_chg;
    logic [2:0]    o_state;
    logic          o_running;

    always #5 i_Clk = ~i_Clk;

    traffic_sched #(
        .NUM_LANES  (NL),
        .TICK_DIV   (TD),
        .LANE_SKEW  (SKEW),
        .MAX_LEVEL  (MAXL),
        .HOLD_TICKS (HOLD)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst_n     (i_Rst_n),
        .i_start     (i_start),
        .i_goal      (i_goal),
        .i_hit       (i_hit),
        .i_pause     (i_pause),
        .o_lane_step (o_lane_step),
        .o_level     (o_level),
        .o_level_chg (o_level_chg),
        .o_state     (o_state),
        .o_running   (o_running)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int step_cnt  [NL];
    int last_step [NL];
    int prev_step [NL];
    int chg_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge i_Clk) cyc++;

    always @(negedge i_Clk) begin
        if (i_Rst_n) begin
            for (int k = 0; k < NL; k++) begin
                if (o_lane_step[k]) begin
                    step_cnt[k]++;
                    prev_step[k] = last_step[k];
                    last_step[k] = cyc;
                end
            end
            if (o_level_chg) chg_cnt++;
        end
    end

    // ---------------- behavioural model ----------------
    logic [W-1:0] exp_q[$];
    game_state_e  m_state, m_nxt;
    int           m_level = 1;
    int           m_phase = 0;
    int           m_run_ticks = 0;
    int           m_hold = 0;
    logic [NL-1:0] m_step;
    logic         m_chg;
    logic         m_tick;

    function automatic int lane_period(input int lvl, input int k);
        return (1100 - 100 * lvl) + k * SKEW;
    endfunction

    always @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            m_state     = ST_IDLE;
            m_level     = 1;
            m_phase     = 0;
            m_run_ticks = 0;
            m_hold      = 0;
            m_step      = '0;
            m_chg       = 1'b0;
            exp_q.delete();
        end else begin
            m_tick = ((m_state == ST_RUN) || (m_state == ST_LEVEL_UP)) && (m_phase == TD - 1);
            m_nxt  = m_state;
            m_step = '0;
            m_chg  = 1'b0;
            case (m_state)
                ST_IDLE, ST_OVER: begin
                    if (i_start) begin
                        m_nxt   = ST_RUN;
                        m_chg   = (m_level != 1);
                        m_level = 1;
                    end
                end
                ST_RUN: begin
                    if (i_hit) m_nxt = ST_OVER;
                    else if (i_goal) begin
                        m_nxt = ST_LEVEL_UP;
                        if (m_level < MAXL) begin
                            m_level++;
                            m_chg = 1'b1;
                        end
                    end else if (i_pause) m_nxt = ST_PAUSE;
                end
                ST_PAUSE: if (!i_pause) m_nxt = ST_RUN;
                ST_LEVEL_UP: begin
                    if (m_tick) m_hold++;
                    if (m_hold == HOLD) m_nxt = i_pause ? ST_PAUSE : ST_RUN;
                end
                default: ;
            endcase
            if (m_nxt != ST_LEVEL_UP) m_hold = 0;

            if ((m_state == ST_RUN) && m_tick) begin
                m_run_ticks++;
                if (m_nxt == ST_RUN)
                    for (int k = 0; k < NL; k++)
                        if (m_run_ticks % lane_period(m_level, k) == 0) m_step[k] = 1'b1;
            end
            if ((m_state == ST_IDLE) || (m_state == ST_OVER) || (m_state == ST_LEVEL_UP))
                m_run_ticks = 0;

            if ((m_state == ST_IDLE) || (m_state == ST_OVER)) m_phase = 0;
            else if ((m_state == ST_RUN) || (m_state == ST_LEVEL_UP)) m_phase = (m_phase + 1) % TD;

            m_state = m_nxt;
            exp_q.push_back({m_state, 4'(m_level), (m_state == ST_RUN), m_chg, m_step});
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge i_Clk) begin
        logic [W-1:0] e;
        if (!i_Rst_n) begin
            check("rst_state", o_state, ST_IDLE);
            check("rst_level", o_level, 1);
            check("rst_step", o_lane_step, 0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state",     o_state,     e[W-1 -: 3]);
            check("level",     o_level,     e[W-4 -: 4]);
            check("running",   o_running,   e[NL+1]);
            check("level_chg", o_level_chg, e[NL]);
            check("lane_step", o_lane_step, e[NL-1:0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step_clk(input int n);
        repeat (n) @(negedge i_Clk);
        #1;
    endtask

    task automatic drive_pulse(input logic s, input logic g, input logic h);
        step_clk(1);
        i_start = s;
        i_goal  = g;
        i_hit   = h;
        step_clk(1);
        i_start = 1'b0;
        i_goal  = 1'b0;
        i_hit   = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while ((o_state != s) && (n < budget)) begin
            step_clk(1);
            n++;
        end
        check(name, o_state, s);
    endtask

    task automatic wait_lane0(input int budget, input string name);
        int base = step_cnt[0];
        int n = 0;
        while ((step_cnt[0] == base) && (n < budget)) begin
            step_clk(1);
            n++;
        end
        check(name, (step_cnt[0] != base), 1);
    endtask

    task automatic clear_steps();
        for (int k = 0; k < NL; k++) begin
            step_cnt[k]  = 0;
            last_step[k] = 0;
            prev_step[k] = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int chg_base;
        int steps_snap;
        int t_ref;

        step_clk(3);
        check("reset_running", o_running, 0);
        check("reset_chg", o_level_chg, 0);
        @(posedge i_Clk);
        #3 i_Rst_n = 1'b1;
        step_clk(2);
        check("idle_hold", o_state, ST_IDLE);

        // Level 1 start: lane periods 4000 / 4008 clocks
        drive_pulse(1'b1, 1'b0, 1'b0);
        check("t1_running", o_running, 1);
        check("t1_state", o_state, ST_RUN);
        clear_steps();
        step_clk(8100);
        check("t1_lane0_count", step_cnt[0], 2);
        check("t1_lane0_period", last_step[0] - prev_step[0], 4000);
        check("t1_lane1_count", step_cnt[1], 2);
        check("t1_lane1_period", last_step[1] - prev_step[1], 4008);

        // Nine goals: level saturates at 9, eight change pulses
        chg_base = chg_cnt;
        for (int i = 1; i <= 9; i++) begin
            drive_pulse(1'b0, 1'b1, 1'b0);
            wait_state(ST_RUN, 100, "t2_back_to_run");
            check("t2_level", o_level, (i + 1 > MAXL) ? MAXL : i + 1);
        end
        check("t2_chg_pulses", chg_cnt - chg_base, 8);
        clear_steps();
        step_clk(1700);
        check("t2_l9_enough_steps", (step_cnt[0] >= 2), 1);
        check("t2_l9_lane0_period", last_step[0] - prev_step[0], 800);

        // Pause 500 clocks mid-count
        wait_lane0(1000, "t3_first_step");
        t_ref = last_step[0];
        step_clk(200);
        i_pause = 1'b1;
        steps_snap = step_cnt[0] + step_cnt[1];
        step_clk(1);
        check("t3_paused", o_state, ST_PAUSE);
        step_clk(499);
        i_pause = 1'b0;
        check("t3_no_steps", step_cnt[0] + step_cnt[1], steps_snap);
        wait_lane0(1500, "t3_resume_step");
        check("t3_delayed_period", last_step[0] - t_ref, 1300);

        // Hit and goal together: hit wins
        drive_pulse(1'b0, 1'b1, 1'b1);
        check("t4_over", o_state, ST_OVER);
        check("t4_level_kept", o_level, 9);
        steps_snap = step_cnt[0] + step_cnt[1];
        step_clk(100);
        check("t4_no_steps", step_cnt[0] + step_cnt[1], steps_snap);
        chg_base = chg_cnt;
        drive_pulse(1'b1, 1'b0, 1'b0);
        check("t4_restart", o_state, ST_RUN);
        check("t4_level_one", o_level, 1);
        check("t4_chg", o_level_chg, 1);
        check("t4_chg_count", chg_cnt - chg_base, 1);

        // Async reset in the middle of LEVEL_UP
        drive_pulse(1'b0, 1'b1, 1'b0);
        check("t5_level_up", o_state, ST_LEVEL_UP);
        check("t5_level", o_level, 2);
        check("t5_chg", o_level_chg, 1);
        #1 i_Rst_n = 1'b0;
        #1;
        check("t5_async_state", o_state, ST_IDLE);
        check("t5_async_level", o_level, 1);
        check("t5_async_chg", o_level_chg, 0);
        check("t5_async_running", o_running, 0);
        check("t5_async_step", o_lane_step, 0);
        step_clk(3);
        @(posedge i_Clk);
        #3 i_Rst_n = 1'b1;
        step_clk(2);

        // Ignored events: start in RUN, hit/goal in PAUSE
        drive_pulse(1'b1, 1'b0, 1'b0);
        drive_pulse(1'b0, 1'b1, 1'b0);
        wait_state(ST_RUN, 100, "t6_run");
        chg_base = chg_cnt;
        drive_pulse(1'b1, 1'b0, 1'b0);
        check("t6_start_ignored", o_state, ST_RUN);
        check("t6_level_kept", o_level, 2);
        check("t6_no_chg", chg_cnt - chg_base, 0);
        i_pause = 1'b1;
        step_clk(1);
        check("t6_pause", o_state, ST_PAUSE);
        drive_pulse(1'b0, 1'b0, 1'b1);
        check("t6_hit_ignored", o_state, ST_PAUSE);
        drive_pulse(1'b0, 1'b1, 1'b0);
        check("t6_goal_ignored", o_state, ST_PAUSE);
        check("t6_level_pause", o_level, 2);
        i_pause = 1'b0;
        step_clk(2);
        check("t6_resume", o_state, ST_RUN);

        // Random game events, checked cycle by cycle against the model
        for (int i = 0; i < 20000; i++) begin
            step_clk(1);
            i_start = ($urandom_range(0, 299) == 0);
            i_goal  = ($urandom_range(0, 1499) == 0);
            i_hit   = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 799) == 0) i_pause = ~i_pause;
        end
        i_start = 1'b0;
        i_goal  = 1'b0;
        i_hit   = 1'b0;
        i_pause = 1'b0;
        step_clk(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
